// File: rtl/commit_trace_buffer_if.sv
// commit_trace_buffer_if: commit capture and trace readout bundle of commit_trace_buffer.
interface commit_trace_buffer_if #(
    parameter int XLEN    = 32,
    parameter int CYCLE_W = 64
);
    logic               commit_valid;
    logic [XLEN-1:0]    commit_pc;
    logic [31:0]        commit_instr;
    logic [4:0]         commit_rd;
    logic               commit_rd_we;
    logic [XLEN-1:0]    commit_wdata;
    logic               out_valid;
    logic               out_ready;
    logic [CYCLE_W-1:0] out_cycle;
    logic [XLEN-1:0]    out_pc;
    logic [31:0]        out_instr;
    logic [4:0]         out_rd;
    logic               out_rd_we;
    logic [XLEN-1:0]    out_wdata;
    logic               out_last;

    modport slave (
        input  commit_valid, commit_pc, commit_instr, commit_rd, commit_rd_we, commit_wdata, out_ready,
        output out_valid, out_cycle, out_pc, out_instr, out_rd, out_rd_we, out_wdata, out_last
    );
    modport master (
        output commit_valid, commit_pc, commit_instr, commit_rd, commit_rd_we, commit_wdata, out_ready,
        input  out_valid, out_cycle, out_pc, out_instr, out_rd, out_rd_we, out_wdata, out_last
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: circular trace of retired instructions, frozen a set number of commits
// after a trigger and streamed out oldest-first over valid/ready.
module commit_trace_buffer #(
    parameter int DEPTH     = 64,
    parameter int XLEN      = 32,
    parameter int CYCLE_W   = 64,
    parameter int POST_TRIG = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_arm,
    input  logic                   i_trig_ext,
    input  logic                   i_trig_pc_en,
    input  logic [XLEN-1:0]        i_trig_pc,
    commit_trace_buffer_if.slave   bus,
    output logic [1:0]             o_state,
    output logic                   o_wrapped
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
    typedef struct packed {
        logic [CYCLE_W-1:0] cycle;
        logic [XLEN-1:0]    pc;
        logic [31:0]        instr;
        logic [4:0]         rd;
        logic               rd_we;
        logic [XLEN-1:0]    wdata;
    } entry_t;

    entry_t             r_mem [DEPTH];
    state_t             r_state, w_state_nxt;
    logic [CYCLE_W-1:0] r_cycle;
    logic [AW-1:0]      r_wr_ptr, r_post_cnt, w_rd_ptr;
    logic [AW:0]        r_count;
    logic               r_wrapped;
    logic               w_trig, w_we, w_xfer, w_full, w_post_done;
    entry_t             w_head;

    assign w_trig      = i_trig_ext | (i_trig_pc_en & bus.commit_valid & (bus.commit_pc == i_trig_pc));
    assign w_we        = bus.commit_valid & ~i_arm & ((r_state == ARMED) | (r_state == POST));
    assign w_full      = r_count == (AW+1)'(DEPTH);
    assign w_xfer      = bus.out_valid & bus.out_ready;
    assign w_post_done = bus.commit_valid & ((r_post_cnt + 1'b1) == AW'(POST_TRIG));
    // In DONE the count is the number still to read, so the oldest unread entry sits count behind wr_ptr.
    assign w_rd_ptr    = r_wr_ptr - r_count[AW-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARMED:   w_state_nxt = w_trig ? ((POST_TRIG == 0) ? DONE : POST) : ARMED;
            POST:    w_state_nxt = w_post_done ? DONE : POST;
            DONE:    w_state_nxt = ((r_count == '0) || (w_xfer && r_count == (AW+1)'(1))) ? IDLE : DONE;
            default: w_state_nxt = r_state;
        endcase
        if (i_arm) w_state_nxt = ARMED;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle    <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_wrapped  <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
            if (i_arm) begin
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_post_cnt <= '0;
                r_wrapped  <= 1'b0;
            end else if (w_we) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_count    <= w_full ? r_count : r_count + 1'b1;
                r_wrapped  <= r_wrapped | w_full;
                // The trigger-cycle commit (stored while still ARMED) does not count toward the post window.
                r_post_cnt <= (r_state == POST) ? r_post_cnt + 1'b1 : '0;
            end else if (w_xfer) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wr_ptr] <= {r_cycle, bus.commit_pc, bus.commit_instr, bus.commit_rd,
                                      bus.commit_rd_we, bus.commit_wdata};
    end

    assign w_head        = r_mem[w_rd_ptr];
    assign bus.out_valid = (r_state == DONE) & (r_count != '0);
    assign bus.out_last  = bus.out_valid & (r_count == (AW+1)'(1));
    assign bus.out_cycle = w_head.cycle;
    assign bus.out_pc    = w_head.pc;
    assign bus.out_instr = w_head.instr;
    assign bus.out_rd    = w_head.rd;
    assign bus.out_rd_we = w_head.rd_we;
    assign bus.out_wdata = w_head.wdata;
    assign o_state       = r_state;
    assign o_wrapped     = r_wrapped;
endmodule
